// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage in front of the MEM/WB register.
//
// Loads and stores go through a shared 8-bit RAM port, one byte per access, little-endian.
// busy_out stays high while an access is in flight so that MEM/WB inserts bubbles.
// Non-memory instructions pass straight through combinationally.
//
// Optional feature macro: MEM_ALIGN_CHECK_EN
//   defined   - misaligned LH/LHU/SH/LW/SW finish at once with no RAM traffic and pulse
//               misalign_out in their DONE cycle (mem_we forced low)
//   undefined - misalign_out tied low; unaligned accesses proceed byte-wise
//
// Parameters:
//   RD_LAT       cycles from a granted read-address cycle to valid ram_din (1..3)
// Ports:
//   clk_in, rst_in               clock, asynchronous active-low reset
//   rdy_in                       global ready; 0 freezes all state and drops ram_req
//   ex_we/ex_w_addr/ex_w_data    register write-back request from EX/MEM
//   ex_mem_op                    0 NONE,1 LB,2 LH,3 LW,4 LBU,5 LHU,6 SB,7 SH,8 SW (9..15 NONE)
//   ex_mem_addr, ex_st_data      effective byte address and store data
//   ram_gnt, ram_din             arbiter grant and read data
//   mem_we/mem_w_addr/mem_w_data write-back to MEM/WB
//   busy_out                     stage busy; upstream holds ex_* stable while high
//   ram_req/ram_wr/ram_addr/ram_dout   RAM port request
//   misalign_out                 misaligned-access pulse (optional feature)

module mem_stage #(
    parameter int unsigned RD_LAT = 1
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        ex_we,
    input  logic [31:0] ex_w_addr,
    input  logic [31:0] ex_w_data,
    input  logic [3:0]  ex_mem_op,
    input  logic [31:0] ex_mem_addr,
    input  logic [31:0] ex_st_data,
    input  logic        ram_gnt,
    input  logic [7:0]  ram_din,
    output logic        mem_we,
    output logic [31:0] mem_w_addr,
    output logic [31:0] mem_w_data,
    output logic        busy_out,
    output logic        ram_req,
    output logic        ram_wr,
    output logic [31:0] ram_addr,
    output logic [7:0]  ram_dout,
    output logic        misalign_out
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StWait  = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    localparam logic [3:0] OpLb  = 4'd1;
    localparam logic [3:0] OpLh  = 4'd2;
    localparam logic [3:0] OpLw  = 4'd3;
    localparam logic [3:0] OpLbu = 4'd4;
    localparam logic [3:0] OpLhu = 4'd5;
    localparam logic [3:0] OpSb  = 4'd6;
    localparam logic [3:0] OpSh  = 4'd7;
    localparam logic [3:0] OpSw  = 4'd8;

    localparam logic [1:0] WaitLast = 2'(RD_LAT - 1);

    logic [1:0]  state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [2:0]  n_q, n_d;
    logic [1:0]  wait_q, wait_d;
    logic [31:0] asm_q, asm_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] st_q, st_d;
    logic        we_q, we_d;
    logic [31:0] waddr_q, waddr_d;
    logic        mis_q, mis_d;

    logic        ex_is_load, ex_is_store, ex_is_mem;
    logic [2:0]  ex_n;
    logic        is_load_q, is_store_q;
    logic        last_byte;
    logic [31:0] load_val;

    assign ex_is_load  = (ex_mem_op >= OpLb) && (ex_mem_op <= OpLhu);
    assign ex_is_store = (ex_mem_op >= OpSb) && (ex_mem_op <= OpSw);
    assign ex_is_mem   = ex_is_load || ex_is_store;
    assign is_load_q   = (op_q >= OpLb) && (op_q <= OpLhu);
    assign is_store_q  = (op_q >= OpSb) && (op_q <= OpSw);
    assign last_byte   = ({1'b0, cnt_q} == (n_q - 3'd1));

    always_comb begin
        ex_n = 3'd1;
        case (ex_mem_op)
            OpLh, OpLhu, OpSh: ex_n = 3'd2;
            OpLw, OpSw:        ex_n = 3'd4;
            default:           ex_n = 3'd1;
        endcase
    end

`ifdef MEM_ALIGN_CHECK_EN
    logic ex_misaligned;
    assign ex_misaligned = ((ex_n == 3'd2) && ex_mem_addr[0]) ||
                           ((ex_n == 3'd4) && (ex_mem_addr[1:0] != 2'b00));
`endif

    always_comb begin
        load_val = 32'd0;
        case (op_q)
            OpLb:    load_val = {{24{asm_q[7]}}, asm_q[7:0]};
            OpLbu:   load_val = {24'd0, asm_q[7:0]};
            OpLh:    load_val = {{16{asm_q[15]}}, asm_q[15:0]};
            OpLhu:   load_val = {16'd0, asm_q[15:0]};
            OpLw:    load_val = asm_q;
            default: load_val = 32'd0;
        endcase
    end

    // Next-state logic; nothing moves while rdy_in is low.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        wait_d  = wait_q;
        asm_d   = asm_q;
        op_d    = op_q;
        addr_d  = addr_q;
        st_d    = st_q;
        we_d    = we_q;
        waddr_d = waddr_q;
        mis_d   = mis_q;
        if (rdy_in) begin
            case (state_q)
                StIdle: begin
                    if (ex_is_mem) begin
                        op_d    = ex_mem_op;
                        addr_d  = ex_mem_addr;
                        st_d    = ex_st_data;
                        we_d    = ex_we;
                        waddr_d = ex_w_addr;
                        n_d     = ex_n;
                        cnt_d   = 2'd0;
                        wait_d  = 2'd0;
                        asm_d   = 32'd0;
                        mis_d   = 1'b0;
                        state_d = StIssue;
`ifdef MEM_ALIGN_CHECK_EN
                        if (ex_misaligned) begin
                            mis_d   = 1'b1;
                            state_d = StDone;
                        end
`endif
                    end
                end
                StIssue: begin
                    if (ram_gnt) begin
                        if (is_store_q) begin
                            if (last_byte) begin
                                state_d = StDone;
                            end else begin
                                cnt_d = cnt_q + 2'd1;
                            end
                        end else begin
                            wait_d  = 2'd0;
                            state_d = StWait;
                        end
                    end
                end
                StWait: begin
                    if (wait_q == WaitLast) begin
                        asm_d[{cnt_q, 3'b000} +: 8] = ram_din;
                        if (last_byte) begin
                            state_d = StDone;
                        end else begin
                            cnt_d   = cnt_q + 2'd1;
                            state_d = StIssue;
                        end
                    end else begin
                        wait_d = wait_q + 2'd1;
                    end
                end
                StDone: begin
                    mis_d   = 1'b0;
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= StIdle;
            cnt_q   <= 2'd0;
            n_q     <= 3'd0;
            wait_q  <= 2'd0;
            asm_q   <= 32'd0;
            op_q    <= 4'd0;
            addr_q  <= 32'd0;
            st_q    <= 32'd0;
            we_q    <= 1'b0;
            waddr_q <= 32'd0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            wait_q  <= wait_d;
            asm_q   <= asm_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            st_q    <= st_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            mis_q   <= mis_d;
        end
    end

    // Outputs are gated by rst_in so the pass-through path is also silent during reset.
    always_comb begin
        mem_we       = 1'b0;
        mem_w_addr   = 32'd0;
        mem_w_data   = 32'd0;
        busy_out     = 1'b0;
        ram_req      = 1'b0;
        ram_wr       = 1'b0;
        ram_addr     = 32'd0;
        ram_dout     = 8'd0;
        misalign_out = 1'b0;
        if (rst_in) begin
            case (state_q)
                StIdle: begin
                    if (ex_is_mem) begin
                        busy_out = 1'b1;
                    end else begin
                        mem_we     = ex_we;
                        mem_w_addr = ex_w_addr;
                        mem_w_data = ex_w_data;
                    end
                end
                StIssue: begin
                    busy_out = 1'b1;
                    ram_req  = rdy_in;
                    ram_wr   = is_store_q;
                    ram_addr = addr_q + {30'd0, cnt_q};
                    if (is_store_q) begin
                        ram_dout = st_q[{cnt_q, 3'b000} +: 8];
                    end
                end
                StWait: begin
                    busy_out = 1'b1;
                end
                StDone: begin
                    mem_we     = we_q && !mis_q;
                    mem_w_addr = waddr_q;
                    mem_w_data = (is_load_q && !mis_q) ? load_val : 32'd0;
`ifdef MEM_ALIGN_CHECK_EN
                    misalign_out = mis_q;
`endif
                end
                default: busy_out = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage. The stimulus process pushes expected write-back results and
// expected RAM port transactions; a monitor process pops and compares them as the DUT presents
// completions and granted RAM cycles.

module tb_mem_stage;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        ex_we;
    logic [31:0] ex_w_addr;
    logic [31:0] ex_w_data;
    logic [3:0]  ex_mem_op;
    logic [31:0] ex_mem_addr;
    logic [31:0] ex_st_data;
    logic        ram_gnt;
    logic [7:0]  ram_din;
    logic        mem_we;
    logic [31:0] mem_w_addr;
    logic [31:0] mem_w_data;
    logic        busy_out;
    logic        ram_req;
    logic        ram_wr;
    logic [31:0] ram_addr;
    logic [7:0]  ram_dout;
    logic        misalign_out;

    localparam logic [3:0] OpNone = 4'd0;
    localparam logic [3:0] OpLb   = 4'd1;
    localparam logic [3:0] OpLh   = 4'd2;
    localparam logic [3:0] OpLw   = 4'd3;
    localparam logic [3:0] OpLbu  = 4'd4;
    localparam logic [3:0] OpLhu  = 4'd5;
    localparam logic [3:0] OpSb   = 4'd6;
    localparam logic [3:0] OpSh   = 4'd7;
    localparam logic [3:0] OpSw   = 4'd8;

    typedef struct packed {
        logic        we;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [7:0]  busy;
        logic        mis;
    } res_t;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [7:0]  dout;
    } ramx_t;

    res_t   exp_res[$];
    string  exp_name[$];
    ramx_t  exp_ram[$];
    int     checks = 0;
    int     errors = 0;
    logic   ex_valid = 1'b0;
    int     busy_cnt = 0;

    mem_stage #(.RD_LAT(1)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .ex_we        (ex_we),
        .ex_w_addr    (ex_w_addr),
        .ex_w_data    (ex_w_data),
        .ex_mem_op    (ex_mem_op),
        .ex_mem_addr  (ex_mem_addr),
        .ex_st_data   (ex_st_data),
        .ram_gnt      (ram_gnt),
        .ram_din      (ram_din),
        .mem_we       (mem_we),
        .mem_w_addr   (mem_w_addr),
        .mem_w_data   (mem_w_data),
        .busy_out     (busy_out),
        .ram_req      (ram_req),
        .ram_wr       (ram_wr),
        .ram_addr     (ram_addr),
        .ram_dout     (ram_dout),
        .misalign_out (misalign_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name, input string info);
        checks++;
        errors++;
        $display("FAIL %s actual=%s required=expected-event", name, info);
    endtask

    // RAM model with one cycle of read latency; unwritten bytes read as 0.
    initial begin
        logic [7:0] mem [logic [31:0]];
        mem[32'h100] = 8'h78; mem[32'h101] = 8'h56; mem[32'h102] = 8'h34; mem[32'h103] = 8'h12;
        mem[32'h104] = 8'h9A; mem[32'h105] = 8'hBC;
        mem[32'h20]  = 8'h80;
        mem[32'h40]  = 8'hFE; mem[32'h41]  = 8'h8F;
        ram_din = 8'h00;
        forever begin
            @(posedge clk_in);
            if (rst_in && rdy_in && ram_req && ram_gnt) begin
                if (ram_wr) begin
                    mem[ram_addr] = ram_dout;
                end else begin
                    ram_din <= mem.exists(ram_addr) ? mem[ram_addr] : 8'h00;
                end
            end
        end
    end

    // Monitor: granted RAM cycles and write-back completions.
    initial begin
        forever begin
            @(negedge clk_in);
            if (!rst_in) begin
                busy_cnt = 0;
            end else if (rdy_in) begin
                if (ram_req && ram_gnt) begin
                    if (exp_ram.size() == 0) begin
                        fail_now("ram_txn", "unexpected");
                    end else begin
                        ramx_t x;
                        x = exp_ram.pop_front();
                        chk("ram_wr", {31'd0, ram_wr}, {31'd0, x.wr});
                        chk("ram_addr", ram_addr, x.addr);
                        if (x.wr) chk("ram_dout", {24'd0, ram_dout}, {24'd0, x.dout});
                    end
                end
                if (busy_out) begin
                    busy_cnt++;
                end else if (ex_valid) begin
                    if (exp_res.size() == 0) begin
                        fail_now("result", "unexpected");
                    end else begin
                        res_t  r;
                        string n;
                        r = exp_res.pop_front();
                        n = exp_name.pop_front();
                        chk({n, "_we"}, {31'd0, mem_we}, {31'd0, r.we});
                        chk({n, "_waddr"}, mem_w_addr, r.waddr);
                        chk({n, "_wdata"}, mem_w_data, r.wdata);
                        chk({n, "_busy"}, busy_cnt, {24'd0, r.busy});
                        chk({n, "_mis"}, {31'd0, misalign_out}, {31'd0, r.mis});
                    end
                    busy_cnt = 0;
                end
            end
        end
    end

    task automatic exp_rd(input logic [31:0] a);
        ramx_t x;
        x.wr = 1'b0; x.addr = a; x.dout = 8'h00;
        exp_ram.push_back(x);
    endtask

    task automatic exp_wr(input logic [31:0] a, input logic [7:0] d);
        ramx_t x;
        x.wr = 1'b1; x.addr = a; x.dout = d;
        exp_ram.push_back(x);
    endtask

    // Present one instruction and hold it until the stage completes it, as upstream would.
    task automatic do_op(input logic [3:0] op, input logic we, input logic [31:0] waddr,
                         input logic [31:0] wdata, input logic [31:0] addr,
                         input logic [31:0] st, input logic exp_we, input logic [31:0] exp_data,
                         input int busy, input logic mis, input string name);
        res_t r;
        int   n = 0;
        bit   done = 1'b0;
        r.we = exp_we; r.waddr = waddr; r.wdata = exp_data; r.busy = 8'(busy); r.mis = mis;
        exp_res.push_back(r);
        exp_name.push_back(name);
        ex_mem_op = op; ex_we = we; ex_w_addr = waddr; ex_w_data = wdata;
        ex_mem_addr = addr; ex_st_data = st;
        ex_valid = 1'b1;
        while (!done) begin
            @(negedge clk_in);
            if (rst_in && rdy_in && !busy_out) begin
                done = 1'b1;
            end else if (++n > 60) begin
                fail_now({name, "_timeout"}, "no-completion");
                done = 1'b1;
            end
        end
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in = 1'b1;
        rdy_in = 1'b1;
        ram_gnt = 1'b1;
        ex_mem_op = OpNone; ex_we = 1'b1; ex_w_addr = 32'd5; ex_w_data = 32'hDEADBEEF;
        ex_mem_addr = 32'd0; ex_st_data = 32'd0;
        #1 rst_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_waddr", mem_w_addr, 32'd0);
        chk("rst_wdata", mem_w_data, 32'd0);
        chk("rst_busy", {31'd0, busy_out}, 32'd0);
        chk("rst_ram_req", {31'd0, ram_req}, 32'd0);
        chk("rst_mis", {31'd0, misalign_out}, 32'd0);
        @(negedge clk_in);
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;

        // Pass-through and basic loads.
        do_op(OpNone, 1'b1, 32'd5, 32'hDEADBEEF, 32'd0, 32'd0, 1'b1, 32'hDEADBEEF, 0, 1'b0,
              "none");
        exp_rd(32'h100); exp_rd(32'h101); exp_rd(32'h102); exp_rd(32'h103);
        do_op(OpLw, 1'b1, 32'd3, 32'd0, 32'h100, 32'd0, 1'b1, 32'h12345678, 9, 1'b0, "lw");
        exp_rd(32'h20);
        do_op(OpLb, 1'b1, 32'd4, 32'd0, 32'h20, 32'd0, 1'b1, 32'hFFFFFF80, 3, 1'b0, "lb");
        exp_rd(32'h20);
        do_op(OpLbu, 1'b1, 32'd4, 32'd0, 32'h20, 32'd0, 1'b1, 32'h00000080, 3, 1'b0, "lbu");
        exp_rd(32'h40); exp_rd(32'h41);
        do_op(OpLh, 1'b1, 32'd11, 32'd0, 32'h40, 32'd0, 1'b1, 32'hFFFF8FFE, 5, 1'b0, "lh");
        exp_rd(32'h40); exp_rd(32'h41);
        do_op(OpLhu, 1'b1, 32'd12, 32'd0, 32'h40, 32'd0, 1'b1, 32'h00008FFE, 5, 1'b0, "lhu");

        // Stores.
        exp_wr(32'h200, 8'hD4); exp_wr(32'h201, 8'hC3); exp_wr(32'h202, 8'hB2);
        exp_wr(32'h203, 8'hA1);
        do_op(OpSw, 1'b0, 32'd7, 32'h5555, 32'h200, 32'hA1B2C3D4, 1'b0, 32'd0, 5, 1'b0, "sw");
        exp_wr(32'h300, 8'h55);
        do_op(OpSb, 1'b0, 32'd7, 32'd0, 32'h300, 32'h12345655, 1'b0, 32'd0, 2, 1'b0, "sb");

        // SH across the address wrap with the grant withdrawn for two cycles mid-transfer.
        exp_wr(32'hFFFFFFFF, 8'hCD); exp_wr(32'h0, 8'hAB);
        fork
            do_op(OpSh, 1'b0, 32'd8, 32'h11111111, 32'hFFFFFFFF, 32'h0000ABCD, 1'b0, 32'd0, 5,
                  1'b0, "sh_wrap");
            begin
                int n = 0;
                do begin
                    @(negedge clk_in);
                    n++;
                end while (!(ram_req && ram_wr && ram_gnt) && n < 40);
                if (n >= 40) fail_now("sh_first_grant", "none");
                @(posedge clk_in);
                #1 ram_gnt = 1'b0;
                repeat (2) begin
                    @(negedge clk_in);
                    chk("sh_req_held", {31'd0, ram_req}, 32'd1);
                    chk("sh_addr_held", ram_addr, 32'd0);
                end
                @(posedge clk_in);
                #1 ram_gnt = 1'b1;
            end
        join
        exp_rd(32'hFFFFFFFF); exp_rd(32'h0);
        do_op(OpLh, 1'b1, 32'd13, 32'd0, 32'hFFFFFFFF, 32'd0, 1'b1, 32'hFFFFABCD, 5, 1'b0,
              "lh_wrap");
        do_op(4'd12, 1'b1, 32'd9, 32'h13579BDF, 32'h40, 32'd0, 1'b1, 32'h13579BDF, 0, 1'b0,
              "op12_none");

        // Freeze during WAIT, then asynchronous reset in the middle of a LW.
        exp_rd(32'h100); exp_rd(32'h101);
        ex_mem_op = OpLw; ex_we = 1'b1; ex_w_addr = 32'd6; ex_w_data = 32'd0;
        ex_mem_addr = 32'h100; ex_st_data = 32'd0;
        ex_valid = 1'b1;
        begin
            int n = 0;
            do begin
                @(negedge clk_in);
                n++;
            end while (!(ram_req && ram_gnt) && n < 40);
            if (n >= 40) fail_now("frz_first_grant", "none");
        end
        @(posedge clk_in);
        #1 rdy_in = 1'b0;
        repeat (3) begin
            @(negedge clk_in);
            chk("frz_busy", {31'd0, busy_out}, 32'd1);
            chk("frz_req", {31'd0, ram_req}, 32'd0);
        end
        @(posedge clk_in);
        #1 rdy_in = 1'b1;
        @(negedge clk_in);
        chk("frz_wait_req", {31'd0, ram_req}, 32'd0);
        @(negedge clk_in);
        chk("frz_byte1_req", {31'd0, ram_req}, 32'd1);
        chk("frz_byte1_addr", ram_addr, 32'h101);
        #1 rst_in = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy_out}, 32'd0);
        chk("arst_req", {31'd0, ram_req}, 32'd0);
        chk("arst_addr", ram_addr, 32'd0);
        chk("arst_mem_we", {31'd0, mem_we}, 32'd0);
        ex_valid = 1'b0;
        ex_mem_op = OpNone; ex_we = 1'b0;
        repeat (2) @(posedge clk_in);
        #2 rst_in = 1'b1;
        @(posedge clk_in);
        #1;
        exp_rd(32'h20);
        do_op(OpLb, 1'b1, 32'd14, 32'd0, 32'h20, 32'd0, 1'b1, 32'hFFFFFF80, 3, 1'b0,
              "lb_after_rst");

        // Misaligned LW.
`ifdef MEM_ALIGN_CHECK_EN
        do_op(OpLw, 1'b1, 32'd10, 32'd0, 32'h102, 32'd0, 1'b0, 32'd0, 1, 1'b1, "lw_misalign");
`else
        exp_rd(32'h102); exp_rd(32'h103); exp_rd(32'h104); exp_rd(32'h105);
        do_op(OpLw, 1'b1, 32'd10, 32'd0, 32'h102, 32'd0, 1'b1, 32'hBC9A1234, 9, 1'b0,
              "lw_unaligned");
`endif
        ex_valid = 1'b0;
        ex_mem_op = OpNone; ex_we = 1'b0;

        repeat (3) @(posedge clk_in);
        chk("res_queue_empty", exp_res.size(), 32'd0);
        chk("ram_queue_empty", exp_ram.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
